// File: rtl/pu_pkg.sv
// Shared types and the output activation for the streaming MAC processing unit.
package pu_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic MODE_RELU   = 1'b0;
  localparam logic MODE_LINEAR = 1'b1;

  // Shift, optional ReLU, then clamp to the signed data_w range; works on a 64-bit carrier.
  function automatic logic signed [63:0] sat_act(input logic signed [63:0] s_in,
                                                 input int shift,
                                                 input int data_w,
                                                 input logic mode);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = s_in >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (mode != MODE_LINEAR && s <= 64'sd0) return '0;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/pu_mac_stream_if.sv
// Input beat stream and result handshake between the network controller and the MAC unit.
interface pu_mac_stream_if #(
  parameter int DATA_W = 5,
  parameter int LANES  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   x_in;
  logic [LANES*DATA_W-1:0]   w_in;
  logic                      mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_value;
  logic                      zero_flag;

  modport master (
    output in_valid, x_in, w_in, mode, out_ready,
    input  in_ready, out_valid, out_value, zero_flag
  );

  modport slave (
    input  in_valid, x_in, w_in, mode, out_ready,
    output in_ready, out_valid, out_value, zero_flag
  );
endinterface

// File: rtl/pu_adder_tree.sv
// Combinational signed sum of LANES packed products, sign-extended to OUT_W.
import pu_pkg::*;

module pu_adder_tree #(
  parameter int LANES = 4,
  parameter int IN_W  = 10,
  parameter int OUT_W = 13
) (
  input  logic [LANES*IN_W-1:0] prods,
  output logic signed [OUT_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + OUT_W'(signed'(prods[i*IN_W +: IN_W]));
    end
  end

endmodule

// File: rtl/pu_mac_stream.sv
// One neuron evaluation: streamed LANES-wide products accumulated over BEATS, then activated and held.
import pu_pkg::*;

module pu_mac_stream #(
  parameter int DATA_W = 5,
  parameter int LANES  = 4,
  parameter int BEATS  = 1,
  parameter int SHIFT  = 0,
  parameter int ACC_W  = 2*DATA_W + $clog2(LANES*BEATS) + 1
) (
  input logic             clk,
  input logic             rst,
  pu_mac_stream_if.slave  bus
);

  localparam int PW    = 2*DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     beat;
  logic                     in_ready;
  logic                     mode_r;
  logic [LANES*PW-1:0]      prod_p1;
  logic                     p_vld;
  logic                     p_last;
  logic signed [ACC_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  flush_sum;
  logic signed [63:0]       wide_sum;
  logic signed [63:0]       act_full;
  logic [DATA_W-1:0]        act;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_value;
  logic                     zero_flag;

  assign beat = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (beat && beat_cnt == LAST_CNT) state_nxt = FLUSH;
      FLUSH:   state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready = (state == COLLECT);
  end

  // Stage p1: per-lane products registered on each accepted beat
  always_ff @(posedge clk) begin
    if (beat) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p1[i*PW +: PW] <= PW'(signed'(bus.x_in[i*DATA_W +: DATA_W]))
                             * PW'(signed'(bus.w_in[i*DATA_W +: DATA_W]));
      end
    end
  end

  pu_adder_tree #(
    .LANES (LANES),
    .IN_W  (PW),
    .OUT_W (ACC_W)
  ) u_tree (
    .prods (prod_p1),
    .sum   (tree_sum)
  );

  // Stage p2: the last beat's products join the accumulator only inside the flush result
  assign flush_sum = acc + tree_sum;
  assign wide_sum  = 64'(flush_sum);
  assign act_full  = sat_act(wide_sum, SHIFT, DATA_W, mode_r);
  assign act       = DATA_W'(act_full);

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt  <= '0;
      mode_r    <= MODE_RELU;
      p_vld     <= 1'b0;
      p_last    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      zero_flag <= 1'b0;
    end else begin
      p_vld <= beat;
      if (beat) begin
        p_last <= (beat_cnt == LAST_CNT);
        if (beat_cnt == '0) mode_r <= bus.mode;
        if (beat_cnt == LAST_CNT) beat_cnt <= '0;
        else                      beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (state == FLUSH) begin
        out_value <= act;
        zero_flag <= (act == '0);
        out_valid <= 1'b1;
        acc       <= '0;
      end else if (p_vld && !p_last) begin
        acc <= flush_sum;
      end
      if (state == HOLD && bus.out_ready) out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_value = out_value;
  assign bus.zero_flag = zero_flag;

endmodule

// File: tb/tb_pu_mac_stream.sv
// Directed bench: a BEATS=1 and a BEATS=2 instance driven through their interfaces, checked with immediate assertions.
import pu_pkg::*;

module tb_pu_mac_stream;
  localparam int DW = 5;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pu_mac_stream_if #(.DATA_W(DW), .LANES(LN)) bus1 ();
  pu_mac_stream_if #(.DATA_W(DW), .LANES(LN)) bus2 ();

  pu_mac_stream #(.DATA_W(DW), .LANES(LN), .BEATS(1), .SHIFT(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  pu_mac_stream #(.DATA_W(DW), .LANES(LN), .BEATS(2), .SHIFT(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input int sel, input string tag, input logic ov, input logic ir);
    logic ov_o, ir_o;
    ov_o = (sel == 1) ? bus1.out_valid : bus2.out_valid;
    ir_o = (sel == 1) ? bus1.in_ready  : bus2.in_ready;
    chk({tag, ".out_valid"}, 16'(ov_o), 16'(ov));
    chk({tag, ".in_ready"},  16'(ir_o), 16'(ir));
  endtask

  task automatic chk_res(input int sel, input string tag, input logic [4:0] val, input logic zf);
    logic [4:0] v_o;
    logic       z_o;
    v_o = (sel == 1) ? bus1.out_value : bus2.out_value;
    z_o = (sel == 1) ? bus1.zero_flag : bus2.zero_flag;
    chk({tag, ".out_value"}, 16'(v_o), 16'(val));
    chk({tag, ".zero_flag"}, 16'(z_o), 16'(zf));
  endtask

  task automatic drive_beat(input int sel, input logic [19:0] x, input logic [19:0] w, input logic m);
    if (sel == 1) begin
      bus1.in_valid = 1'b1; bus1.x_in = x; bus1.w_in = w; bus1.mode = m;
    end else begin
      bus2.in_valid = 1'b1; bus2.x_in = x; bus2.w_in = w; bus2.mode = m;
    end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
  endtask

  // Called just after the last beat's edge: FLUSH cycle, then HOLD with the result.
  task automatic expect_result(input int sel, input string tag, input logic [4:0] val, input logic zf);
    @(negedge clk);
    chk_ctl(sel, {tag, ".flush"}, 1'b0, 1'b0);
    @(negedge clk);
    chk_ctl(sel, {tag, ".hold"}, 1'b1, 1'b0);
    chk_res(sel, {tag, ".hold"}, val, zf);
  endtask

  task automatic expect_release(input int sel, input string tag);
    @(negedge clk);
    chk_ctl(sel, {tag, ".done"}, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    bus1.in_valid = 1'b0; bus1.x_in = '0; bus1.w_in = '0; bus1.mode = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.x_in = '0; bus2.w_in = '0; bus2.mode = 1'b0; bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ctl(1, "reset1", 1'b0, 1'b1);
    chk_res(1, "reset1", 5'd0, 1'b0);
    chk_ctl(2, "reset2", 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Sum 10 in ReLU mode, then held for five cycles under backpressure with a beat on offer
    drive_beat(1, pk(1, 2, 3, 4), pk(1, 1, 1, 1), MODE_RELU);
    expect_result(1, "sum10", 5'd10, 1'b0);
    bus1.in_valid = 1'b1;
    bus1.x_in = pk(7, 7, 7, 7); bus1.w_in = pk(7, 7, 7, 7); bus1.mode = MODE_LINEAR;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_ctl(1, "bp", 1'b1, 1'b0);
      chk_res(1, "bp", 5'd10, 1'b0);
    end
    @(posedge clk); #1;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    chk_ctl(1, "bp.hold_last", 1'b1, 1'b0);
    @(posedge clk); #1;
    expect_release(1, "bp");

    // Negative sum -24: ReLU clips to zero, linear saturates to -16
    drive_beat(1, pk(-3, -3, -3, -3), pk(2, 2, 2, 2), MODE_RELU);
    expect_result(1, "neg_relu", 5'd0, 1'b1);
    @(posedge clk); #1;
    expect_release(1, "neg_relu");

    drive_beat(1, pk(-3, -3, -3, -3), pk(2, 2, 2, 2), MODE_LINEAR);
    expect_result(1, "neg_lin", 5'h10, 1'b0);
    @(posedge clk); #1;
    expect_release(1, "neg_lin");

    // Sum 900 saturates to the positive limit
    drive_beat(1, pk(15, 15, 15, 15), pk(15, 15, 15, 15), MODE_RELU);
    expect_result(1, "pos_sat", 5'h0F, 1'b0);
    @(posedge clk); #1;
    expect_release(1, "pos_sat");
    bus1.out_ready = 1'b0;

    // Two beats (8 then -4) separated by a three-cycle gap
    bus2.out_ready = 1'b1;
    drive_beat(2, pk(1, 1, 1, 1), pk(2, 2, 2, 2), MODE_RELU);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctl(2, "gap", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    drive_beat(2, pk(1, 1, 1, 1), pk(-1, -1, -1, -1), MODE_LINEAR);
    expect_result(2, "two_beat", 5'd4, 1'b0);
    @(posedge clk); #1;
    expect_release(2, "two_beat");

    // Reset after the first beat discards it; the following two beats form a fresh evaluation
    drive_beat(2, pk(1, 1, 1, 1), pk(2, 2, 2, 2), MODE_RELU);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_ctl(2, "mid_reset", 1'b0, 1'b1);
    chk_res(2, "mid_reset", 5'd0, 1'b0);
    drive_beat(2, pk(1, 0, 0, 0), pk(3, 0, 0, 0), MODE_RELU);
    drive_beat(2, pk(1, 0, 0, 0), pk(3, 0, 0, 0), MODE_RELU);
    expect_result(2, "after_reset", 5'd6, 1'b0);
    @(posedge clk); #1;
    expect_release(2, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
